// File: rtl/joy_port_pkg.sv
// Shared types and default timing for the controller port host.
package joy_port_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    GAP,
    CLK_LO,
    CLK_HI,
    DONE
  } joy_state_t;

  localparam int DEF_BITS        = 16;
  localparam int DEF_LATCH_TICKS = 12;
  localparam int DEF_HALF_TICKS  = 6;
  localparam int CNT_W           = 9;

endpackage

// File: rtl/joy_port_oplatch.sv
// Light-sense capture: synchronises P6 and latches the PPU counters on its falling edge.
module joy_port_oplatch
  import joy_port_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             PORT_P6,
  input  logic             LATCH_EN,
  input  logic             OPACK,
  input  logic [CNT_W-1:0] HCNT,
  input  logic [CNT_W-1:0] VCNT,
  output logic [CNT_W-1:0] OPHCT,
  output logic [CNT_W-1:0] OPVCT,
  output logic             OPLATCHED
);

  logic [1:0] p6_sync;
  logic       p6_prev;
  logic       p6_fall;
  logic       capture;

  assign p6_fall = p6_prev & ~p6_sync[1];
  // An acknowledge in the same cycle as an edge frees the slot, so the new capture takes it.
  assign capture = p6_fall & LATCH_EN & (~OPLATCHED | OPACK);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      p6_sync   <= 2'b11;
      p6_prev   <= 1'b1;
      OPHCT     <= '0;
      OPVCT     <= '0;
      OPLATCHED <= 1'b0;
    end else begin
      p6_sync <= {p6_sync[0], PORT_P6};
      p6_prev <= p6_sync[1];
      if (capture) begin
        OPHCT     <= HCNT;
        OPVCT     <= VCNT;
        OPLATCHED <= 1'b1;
      end else if (OPACK) begin
        OPLATCHED <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/joy_port_host.sv
// Console-side controller port master: latch/clock strobes, serial shift-in, atomic publish.
module joy_port_host
  import joy_port_pkg::*;
#(
  parameter int BITS        = DEF_BITS,
  parameter int LATCH_TICKS = DEF_LATCH_TICKS,
  parameter int HALF_TICKS  = DEF_HALF_TICKS
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             START,
  output logic             BUSY,
  output logic             PORT_LATCH,
  output logic             PORT_CLK,
  input  logic [1:0]       PORT_DO,
  input  logic             PORT_P6,
  input  logic             LATCH_EN,
  input  logic [CNT_W-1:0] HCNT,
  input  logic [CNT_W-1:0] VCNT,
  input  logic             OPACK,
  output logic [BITS-1:0]  DATA0,
  output logic [BITS-1:0]  DATA1,
  output logic [CNT_W-1:0] OPHCT,
  output logic [CNT_W-1:0] OPVCT,
  output logic             OPLATCHED,
  output joy_state_t       DBG_STATE
);

  localparam int TMAX = (LATCH_TICKS > HALF_TICKS) ? LATCH_TICKS : HALF_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int NW   = (BITS > 1) ? $clog2(BITS) : 1;

  joy_state_t      state, state_d;
  logic [TW-1:0]   t, t_d;
  logic [NW-1:0]   n, n_d;
  logic [BITS-1:0] sh0, sh0_d, sh1, sh1_d;
  logic            busy_d;
  logic            publish;

  assign DBG_STATE = state;

  // A START seen without CE raises BUSY at once and is held until the next tick.
  always_comb begin
    state_d = state;
    t_d     = t;
    n_d     = n;
    sh0_d   = sh0;
    sh1_d   = sh1;
    busy_d  = BUSY;
    publish = 1'b0;
    case (state)
      IDLE: begin
        if (START) busy_d = 1'b1;
        if (CE && (START || BUSY)) begin
          state_d = LATCH;
          t_d     = '0;
          n_d     = '0;
          busy_d  = 1'b1;
        end
      end
      LATCH: if (CE) begin
        if (t == TW'(LATCH_TICKS - 1)) begin
          state_d = GAP;
          t_d     = '0;
        end else t_d = t + 1'b1;
      end
      GAP: if (CE) begin
        if (t == TW'(HALF_TICKS - 1)) begin
          state_d = CLK_LO;
          t_d     = '0;
        end else t_d = t + 1'b1;
      end
      CLK_LO: if (CE) begin
        if (t == TW'(HALF_TICKS - 1)) begin
          sh0_d   = {sh0[BITS-2:0], ~PORT_DO[0]};
          sh1_d   = {sh1[BITS-2:0], ~PORT_DO[1]};
          state_d = CLK_HI;
          t_d     = '0;
        end else t_d = t + 1'b1;
      end
      CLK_HI: if (CE) begin
        if (t == TW'(HALF_TICKS - 1)) begin
          t_d = '0;
          if (n == NW'(BITS - 1)) begin
            state_d = DONE;
          end else begin
            n_d     = n + 1'b1;
            state_d = CLK_LO;
          end
        end else t_d = t + 1'b1;
      end
      DONE: begin
        publish = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      t          <= '0;
      n          <= '0;
      sh0        <= '0;
      sh1        <= '0;
      BUSY       <= 1'b0;
      PORT_LATCH <= 1'b0;
      PORT_CLK   <= 1'b1;
      DATA0      <= '0;
      DATA1      <= '0;
    end else begin
      state      <= state_d;
      t          <= t_d;
      n          <= n_d;
      sh0        <= sh0_d;
      sh1        <= sh1_d;
      BUSY       <= busy_d;
      PORT_LATCH <= (state_d == LATCH);
      PORT_CLK   <= (state_d != CLK_LO);
      if (publish) begin
        DATA0 <= sh0;
        DATA1 <= sh1;
      end
    end
  end

  joy_port_oplatch u_oplatch (
    .CLK      (CLK),
    .RESET    (RESET),
    .PORT_P6  (PORT_P6),
    .LATCH_EN (LATCH_EN),
    .OPACK    (OPACK),
    .HCNT     (HCNT),
    .VCNT     (VCNT),
    .OPHCT    (OPHCT),
    .OPVCT    (OPVCT),
    .OPLATCHED(OPLATCHED)
  );

endmodule
